// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between the instruction-fetch requester and the
//   load/store requester. Data has fixed priority. A starvation guard hands the
//   port to fetch after MAX_WAIT consecutive data grants while fetch waits.
//   Only one transaction is outstanding at a time. The memory side uses a
//   req/ack handshake with variable latency, and each completion is returned
//   as a one-cycle rvalid pulse to the requester that owns it.
//
// Ports
//   clk_i, reset_i          clock (rising edge), async active-high reset
//   if_req_i/if_addr_i      fetch request (word read)
//   if_gnt_o                fetch accepted this cycle (combinational)
//   if_rvalid_o/if_rdata_o  fetch completion pulse and read data
//   d_req_i/d_we_i/d_size_i/d_addr_i/d_wdata_i   load/store request
//   d_gnt_o                 data accepted this cycle (combinational)
//   d_rvalid_o/d_rdata_o    data completion pulse; rdata is 0 for writes
//   mem_req_o..mem_wdata_o  memory request and registered request fields
//   mem_ack_i/mem_rdata_i   memory completion and read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [1:0]        d_size_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [1:0]        mem_size_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_starve;
  logic                w_starve_max;
  logic                w_if_gnt;
  logic                w_d_gnt;
  logic                w_if_done;
  logic                w_d_done;

  logic                r_mem_we;
  logic [1:0]          r_mem_size;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_if_rvalid;
  logic                r_d_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  assign w_starve_max = (r_starve == CNT_W'(MAX_WAIT));
  assign w_if_done    = (r_state == BUSY_IF) && mem_ack_i;
  assign w_d_done     = (r_state == BUSY_D)  && mem_ack_i;

  // Next-state and grant decode. Grants only exist in IDLE, so an ack seen
  // in IDLE falls through the case untouched and is ignored.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_if_gnt    = 1'b0;
    w_d_gnt     = 1'b0;
    case (r_state)
      IDLE: begin
        // Fetch wins only when data is absent or fetch has waited long enough.
        if (if_req_i && (!d_req_i || w_starve_max)) begin
          w_if_gnt    = 1'b1;
          w_state_nxt = BUSY_IF;
        end else if (d_req_i) begin
          w_d_gnt     = 1'b1;
          w_state_nxt = BUSY_D;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ack_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mem_we    <= 1'b0;
      r_mem_size  <= 2'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_starve    <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      if (w_if_gnt) begin
        r_mem_we    <= 1'b0;
        r_mem_size  <= 2'd2;
        r_mem_addr  <= if_addr_i;
        r_mem_wdata <= '0;
        r_starve    <= '0;
      end else if (w_d_gnt) begin
        r_mem_we    <= d_we_i;
        r_mem_size  <= d_size_i;
        r_mem_addr  <= d_addr_i;
        r_mem_wdata <= d_wdata_i;
        // Count data grants that bypassed a waiting fetch; saturate at the
        // limit, restart when fetch was not waiting.
        if (!if_req_i)          r_starve <= '0;
        else if (!w_starve_max) r_starve <= r_starve + 1'b1;
      end

      r_if_rvalid <= w_if_done;
      r_d_rvalid  <= w_d_done;
      if (w_if_done) r_if_rdata <= mem_rdata_i;
      if (w_d_done)  r_d_rdata  <= r_mem_we ? '0 : mem_rdata_i;
    end
  end

  assign if_gnt_o    = w_if_gnt;
  assign d_gnt_o     = w_d_gnt;
  assign if_rvalid_o = r_if_rvalid;
  assign d_rvalid_o  = r_d_rvalid;
  assign if_rdata_o  = r_if_rdata;
  assign d_rdata_o   = r_d_rdata;
  assign mem_req_o   = (r_state != IDLE);
  assign mem_we_o    = r_mem_we;
  assign mem_size_o  = r_mem_size;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

endmodule
